// File: rtl/dtw_pkg.sv
// Shared DTW definitions: path codes, grid limits, score-bus layout and
// traceback error codes, used by the score cells and the path collector.
package dtw_pkg;

  typedef enum logic [1:0] {
    PATH_RST  = 2'b00,
    PATH_LEFT = 2'b01,
    PATH_UP   = 2'b10,
    PATH_DIAG = 2'b11
  } path_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_STEP    = 2'b10,
    ERR_OVF     = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } pc_state_e;

  localparam int unsigned IDX_W = 5;
  localparam logic [IDX_W-1:0] IDX_LAST    = 5'd30;
  localparam logic [IDX_W-1:0] IDX_INVALID = 5'd31;

  // Bus word: {3'b0, t[4:0], 3'b0, r[4:0], D[15:0]}
  localparam int unsigned BUS_D_LSB = 0;
  localparam int unsigned BUS_D_W   = 16;
  localparam int unsigned BUS_R_LSB = 16;
  localparam int unsigned BUS_T_LSB = 24;

  function automatic logic [IDX_W-1:0] bus_t(input logic [31:0] bus);
    return bus[BUS_T_LSB +: IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] bus_r(input logic [31:0] bus);
    return bus[BUS_R_LSB +: IDX_W];
  endfunction

  function automatic logic [31:0] bus_pack(input logic [IDX_W-1:0] t,
                                           input logic [IDX_W-1:0] r,
                                           input logic [BUS_D_W-1:0] d);
    logic [31:0] w;
    w = '0;
    w[BUS_T_LSB +: IDX_W]   = t;
    w[BUS_R_LSB +: IDX_W]   = r;
    w[BUS_D_LSB +: BUS_D_W] = d;
    return w;
  endfunction

endpackage

// File: rtl/path_collector_if.sv
// Score-bus, control and SRAM-write signals of the path collector.
interface path_collector_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              i_start;
  logic              o_seed;
  logic [31:0]       i_bus;
  logic              i_bus_vld;
  logic              o_sram_we;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [31:0]       o_sram_wdata;
  logic              o_done;
  logic [1:0]        o_err;
  logic [ADDR_W:0]   o_len;

  modport master (
    output i_start, i_bus, i_bus_vld,
    input  o_seed, o_sram_we, o_sram_addr, o_sram_wdata, o_done, o_err, o_len
  );

  modport slave (
    input  i_start, i_bus, i_bus_vld,
    output o_seed, o_sram_we, o_sram_addr, o_sram_wdata, o_done, o_err, o_len
  );
endinterface

// File: rtl/path_collector_step_check.sv
// Combinational legality of one traceback step: (dt,dr) must be
// (-1,-1), (-1,0) or (0,-1), and the new cell must be on the grid.
module step_check
  import dtw_pkg::*;
(
  input  logic [IDX_W-1:0] prev_t_i,
  input  logic [IDX_W-1:0] prev_r_i,
  input  logic [IDX_W-1:0] cur_t_i,
  input  logic [IDX_W-1:0] cur_r_i,
  output logic             legal_o
);
  logic [IDX_W:0] cur_t_inc;
  logic [IDX_W:0] cur_r_inc;
  logic           dt_one, dt_zero, dr_one, dr_zero;

  always_comb begin
    // One extra bit so that cur=31 cannot wrap onto prev=0
    cur_t_inc = {1'b0, cur_t_i} + (IDX_W+1)'(1);
    cur_r_inc = {1'b0, cur_r_i} + (IDX_W+1)'(1);
    dt_one    = ({1'b0, prev_t_i} == cur_t_inc);
    dr_one    = ({1'b0, prev_r_i} == cur_r_inc);
    dt_zero   = (prev_t_i == cur_t_i);
    dr_zero   = (prev_r_i == cur_r_i);
    legal_o   = (cur_t_i != IDX_INVALID) && (cur_r_i != IDX_INVALID) &&
                ((dt_one && dr_one) || (dt_one && dr_zero) || (dt_zero && dr_one));
  end
endmodule

// File: rtl/path_collector.sv
// DTW traceback collector: seeds the final score cell, captures the path
// from the shared score bus and streams each entry into SRAM.
module path_collector
  import dtw_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 4
) (
  input logic             clk,
  input logic             nrst,
  path_collector_if.slave pc
);
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  pc_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [IDX_W-1:0]  prev_t_q, prev_t_d, prev_r_q, prev_r_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  err_e              err_q, err_d;
  logic [ADDR_W:0]   len_q, len_d;

  logic [IDX_W-1:0]  cur_t, cur_r;
  logic              capture, overflow, step_legal, step_bad, at_origin;

  assign cur_t = bus_t(pc.i_bus);
  assign cur_r = bus_r(pc.i_bus);

  step_check u_step_check (
    .prev_t_i (prev_t_q),
    .prev_r_i (prev_r_q),
    .cur_t_i  (cur_t),
    .cur_r_i  (cur_r),
    .legal_o  (step_legal)
  );

  always_comb begin
    capture   = pc.i_bus_vld && ((state_q == ST_SEED) || (state_q == ST_COLLECT));
    overflow  = (cnt_q == CAP);
    at_origin = (cur_t == '0) && (cur_r == '0);
    step_bad  = (cnt_q == '0) ? !((cur_t == IDX_LAST) && (cur_r == IDX_LAST))
                              : !step_legal;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    prev_t_d = prev_t_q;
    prev_r_d = prev_r_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    len_d    = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pc.i_start) begin
          state_d = ST_SEED;
          cnt_d   = '0;
          idle_d  = '0;
          err_d   = ERR_NONE;
          len_d   = '0;
        end
      end

      ST_SEED, ST_COLLECT: begin
        if (capture) begin
          idle_d = '0;
          if (overflow) begin
            state_d = ST_DONE;
            err_d   = ERR_OVF;
            len_d   = cnt_q;
          end else begin
            we_d     = 1'b1;
            addr_d   = cnt_q[ADDR_W-1:0];
            wdata_d  = pc.i_bus;
            cnt_d    = cnt_q + (ADDR_W+1)'(1);
            prev_t_d = cur_t;
            prev_r_d = cur_r;
            // A bad seed entry ends the run straight from SEED so that DONE
            // still coincides with its write.
            if (step_bad) begin
              state_d = ST_DONE;
              err_d   = ERR_STEP;
              len_d   = cnt_q + (ADDR_W+1)'(1);
            end else if (at_origin) begin
              state_d = ST_DONE;
              err_d   = ERR_NONE;
              len_d   = cnt_q + (ADDR_W+1)'(1);
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end else if (state_q == ST_COLLECT) begin
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_DONE;
            err_d   = ERR_TIMEOUT;
            len_d   = cnt_q;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idle_q   <= '0;
      prev_t_q <= '0;
      prev_r_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= ERR_NONE;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      prev_t_q <= prev_t_d;
      prev_r_q <= prev_r_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      len_q    <= len_d;
    end
  end

  assign pc.o_seed       = (state_q == ST_SEED);
  assign pc.o_done       = (state_q == ST_DONE);
  assign pc.o_sram_we    = we_q;
  assign pc.o_sram_addr  = addr_q;
  assign pc.o_sram_wdata = wdata_q;
  assign pc.o_err        = err_q;
  assign pc.o_len        = len_q;

endmodule
